cv32e40x_div_sequencer: RTL

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU, sitting in EX behind the M-extension decode (driven when `div_en` is decoded). It captures operands on a valid/ready handshake and runs a radix-2 restoring division, one quotient bit per cycle. It applies RISC-V sign and corner-case rules and holds the result until EX/WB accepts it. It also owns pipeline-kill handling for the in-flight division.

---
 rtl/cv32e40x_div_sequencer.sv | 96 +++++++++
 1 files changed

// File: rtl/cv32e40x_div_sequencer.sv
// cv32e40x_div_sequencer: radix-2 restoring RV32M divider sequencer; optional corner-case fast path under CV32E40X_DIV_FASTPATH_EN
module cv32e40x_div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [1:0]  div_operator_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);
  typedef enum logic [2:0] {IDLE, INIT, ITER, SIGN, DONE} state_e;
  state_e      state;
  logic [1:0]  operator_q;
  logic        sign_a_q, sign_b_q, divzero_q;
  logic [31:0] b_q;
  logic [63:0] rq;
  logic [5:0]  cnt_q;
  logic        is_signed, is_rem, sa, sb, ge;
  logic [31:0] a_mag, b_mag, diff, quo_s, rem_s;
  // operator encoding follows div_opcode_e: bit0 = signed, bit1 = remainder
  assign is_signed = operator_q[0];
  assign is_rem    = operator_q[1];
  assign sa        = is_signed & rq[31];
  assign sb        = is_signed & b_q[31];
  assign a_mag     = sa ? -rq[31:0] : rq[31:0];
  assign b_mag     = sb ? -b_q : b_q;
  // shifted partial remainder is 33 bits wide; a successful subtract always fits back in 32
  assign ge        = rq[63:31] >= {1'b0, b_q};
  assign diff      = rq[62:31] - b_q;
  assign quo_s     = (sign_a_q ^ sign_b_q) && !divzero_q ? -rq[31:0] : rq[31:0];
  assign rem_s     = sign_a_q ? -rq[63:32] : rq[63:32];
  assign ready_o   = state == IDLE;
  assign valid_o   = state == DONE;
  assign busy_o    = state != IDLE;
`ifdef CV32E40X_DIV_FASTPATH_EN
  logic fast_zero, fast_ovf;
  assign fast_zero = b_q == 32'd0;
  assign fast_ovf  = is_signed && rq[31:0] == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
`endif
  // sequencer FSM: capture, normalise signs, iterate one quotient bit per cycle, fix signs, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      operator_q <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      divzero_q  <= 1'b0;
      b_q        <= '0;
      rq         <= '0;
      cnt_q      <= '0;
      result_o   <= '0;
    end else if (kill_i && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (valid_i && !kill_i) begin
          operator_q <= div_operator_i;
          rq         <= {32'd0, op_a_i};
          b_q        <= op_b_i;
          state      <= INIT;
        end
        INIT: begin
          sign_a_q  <= sa;
          sign_b_q  <= sb;
          divzero_q <= b_q == 32'd0;
          cnt_q     <= 6'd32;
          rq        <= {32'd0, a_mag};
          b_q       <= b_mag;
          state     <= ITER;
`ifdef CV32E40X_DIV_FASTPATH_EN
          if (fast_zero || fast_ovf) begin
            result_o <= fast_zero ? (is_rem ? rq[31:0] : 32'hFFFF_FFFF) : (is_rem ? 32'd0 : 32'h8000_0000);
            state    <= DONE;
          end
`endif
        end
        ITER: begin
          rq    <= ge ? {diff, rq[30:0], 1'b1} : {rq[62:0], 1'b0};
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state <= SIGN;
        end
        SIGN: begin
          result_o <= is_rem ? rem_s : quo_s;
          state    <= DONE;
        end
        DONE: if (ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
